// File: rtl/seq_div.sv
// seq_div: restoring signed divider, one quotient bit per clock, valid/ready on both sides
// Ports: clk/rst_n (async active-low), in_valid/in_ready + dividend[N]/divisor[bit_B] request,
//        out_valid/out_ready + quotient[N]/remainder[bit_B]/div_zero/ovf result, N = bit_A+bit_B.
module seq_div #(
  parameter int bit_A = 5,
  parameter int bit_B = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [bit_A+bit_B-1:0] dividend,
  input  logic [bit_B-1:0]       divisor,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [bit_A+bit_B-1:0] quotient,
  output logic [bit_B-1:0]       remainder,
  output logic                   div_zero,
  output logic                   ovf
);
  localparam int N  = bit_A + bit_B;
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t         state;
  logic [N-1:0]   dvd;
  logic [bit_B-1:0] dvs;
  logic [bit_B:0] pr;
  logic [CW-1:0]  cnt;
  logic           neg_q, neg_r;
  logic [bit_B+1:0] pr_sh;
  logic           ge;
  // dvd doubles as the dividend shifter and the quotient accumulator
  always_comb begin
    pr_sh = {pr, dvd[N-1]};
    ge = pr_sh >= (bit_B+2)'(dvs);
  end
  assign in_ready = (state == IDLE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
      dvd       <= '0;
      dvs       <= '0;
      pr        <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          dvd   <= dividend[N-1] ? -dividend : dividend;
          dvs   <= divisor[bit_B-1] ? -divisor : divisor;
          neg_q <= dividend[N-1] ^ divisor[bit_B-1];
          neg_r <= dividend[N-1];
          pr    <= '0;
          cnt   <= '0;
          if (divisor == '0) begin
            state     <= DONE;
            quotient  <= '1;
            remainder <= '0;
            div_zero  <= 1'b1;
            ovf       <= 1'b0;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          dvd <= {dvd[N-2:0], ge};
          pr  <= ge ? (bit_B+1)'(pr_sh - (bit_B+2)'(dvs)) : pr_sh[bit_B:0];
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N-1)) state <= FIX;
        end
        FIX: begin
          quotient  <= neg_q ? -dvd : dvd;
          remainder <= neg_r ? -pr[bit_B-1:0] : pr[bit_B-1:0];
          // a non-negated magnitude with the MSB set only arises from -2^(N-1) / -1
          ovf       <= !neg_q && dvd[N-1];
          div_zero  <= 1'b0;
          state     <= DONE;
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_div.sv
module tb_seq_div;
  localparam int BA = 5;
  localparam int BB = 7;
  localparam int N  = BA + BB;

  typedef struct {
    logic [N-1:0]  q;
    logic [BB-1:0] r;
    logic          dz;
    logic          ov;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  dividend = '0;
  logic [BB-1:0] divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N-1:0]  quotient;
  logic [BB-1:0] remainder;
  logic          div_zero;
  logic          ovf;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  seq_div #(.bit_A(BA), .bit_B(BB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(int a, int b);
    exp_t e;
    e.dz = 1'b0;
    e.ov = 1'b0;
    if (b == 0) begin
      e.q = '1;
      e.r = '0;
      e.dz = 1'b1;
    end else if (a == -(1 << (N-1)) && b == -1) begin
      e.q = N'(a);
      e.r = '0;
      e.ov = 1'b1;
    end else begin
      e.q = N'(a / b);
      e.r = BB'(a % b);
    end
    return e;
  endfunction

  task automatic start(input int a, input int b);
    sb.push_back(model(a, b));
    @(negedge clk);
    dividend = N'(a);
    divisor  = BB'(b);
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({out_valid, in_ready, quotient, remainder, div_zero, ovf} !== {2'b01, {N{1'b0}}, {BB{1'b0}}, 2'b00}) begin
      errors++;
      $display("FAIL reset_state got ov=%b ir=%b q=%h r=%h dz=%b ovf=%b want 0 1 0 0 0 0",
               out_valid, in_ready, quotient, remainder, div_zero, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    exp_t e;
    start(-945, 63);
    wait_out(lat);
    e = sb.pop_front();
    checks++;
    if (lat !== 14) begin
      errors++;
      $display("FAIL basic_latency got %0d want 14", lat);
    end
    checks++;
    if ({quotient, remainder, div_zero, ovf} !== {e.q, e.r, e.dz, e.ov}) begin
      errors++;
      $display("FAIL basic_result got q=%0d r=%0d dz=%b ovf=%b want q=%0d r=%0d dz=%b ovf=%b",
               $signed(quotient), $signed(remainder), div_zero, ovf, $signed(e.q), $signed(e.r), e.dz, e.ov);
    end
    consume();
    checks++;
    if ({out_valid, in_ready, quotient} !== {2'b01, e.q}) begin
      errors++;
      $display("FAIL basic_consume got ov=%b ir=%b q=%0d want 0 1 q=%0d", out_valid, in_ready, $signed(quotient), $signed(e.q));
    end
  endtask

  task automatic test_signs();
    int lat;
    exp_t e;
    int ops[3][2] = '{'{100, -7}, '{-100, 7}, '{5, -64}};
    for (int i = 0; i < 3; i++) begin
      start(ops[i][0], ops[i][1]);
      wait_out(lat);
      e = sb.pop_front();
      checks++;
      if ({out_valid, quotient, remainder, div_zero, ovf} !== {1'b1, e.q, e.r, e.dz, e.ov}) begin
        errors++;
        $display("FAIL signs_%0d got v=%b q=%0d r=%0d dz=%b ovf=%b want q=%0d r=%0d", i, out_valid,
                 $signed(quotient), $signed(remainder), div_zero, ovf, $signed(e.q), $signed(e.r));
      end
      consume();
    end
  endtask

  task automatic test_div_zero();
    int lat;
    exp_t e;
    start(123, 0);
    wait_out(lat);
    e = sb.pop_front();
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL divzero_latency got %0d want 1", lat);
    end
    checks++;
    if ({quotient, remainder, div_zero, ovf} !== {e.q, e.r, e.dz, e.ov}) begin
      errors++;
      $display("FAIL divzero_result got q=%h r=%h dz=%b ovf=%b want q=%h r=%h dz=%b ovf=%b",
               quotient, remainder, div_zero, ovf, e.q, e.r, e.dz, e.ov);
    end
    consume();
  endtask

  task automatic test_ovf();
    int lat;
    exp_t e;
    start(-2048, -1);
    wait_out(lat);
    e = sb.pop_front();
    checks++;
    if ({out_valid, quotient, remainder, div_zero, ovf} !== {1'b1, e.q, e.r, e.dz, e.ov}) begin
      errors++;
      $display("FAIL ovf_result got v=%b q=%0d r=%0d dz=%b ovf=%b want q=%0d r=0 dz=0 ovf=1",
               out_valid, $signed(quotient), $signed(remainder), div_zero, ovf, $signed(e.q));
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    exp_t e;
    start(77, 5);
    wait_out(lat);
    e = sb.pop_front();
    dividend = N'(-1000);
    divisor  = BB'(3);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, in_ready, quotient, remainder, div_zero, ovf} !== {2'b10, e.q, e.r, e.dz, e.ov}) begin
        errors++;
        $display("FAIL backpressure_hold_%0d got v=%b ir=%b q=%0d r=%0d want v=1 ir=0 q=%0d r=%0d", i,
                 out_valid, in_ready, $signed(quotient), $signed(remainder), $signed(e.q), $signed(e.r));
      end
    end
    in_valid = 1'b0;
    consume();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++;
        $display("FAIL backpressure_ignored_%0d got v=%b ir=%b want v=0 ir=1", i, out_valid, in_ready);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid();
    bit bad = 0;
    start(100, 7);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, quotient, div_zero, ovf} !== {2'b01, {N{1'b0}}, 2'b00}) begin
      errors++;
      $display("FAIL reset_mid_async got v=%b ir=%b q=%h want v=0 ir=1 q=0", out_valid, in_ready, quotient);
    end
    // the aborted request never produces a result
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_mid_idle got v=%b ir=%b want v=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_sweep();
    int lat;
    exp_t e;
    int nerr = 0;
    for (int a = -16; a <= 15; a++) begin
      for (int b = -64; b <= 63; b++) begin
        if (b == 0) continue;
        start(a * b, b);
        wait_out(lat);
        e = sb.pop_front();
        checks++;
        if ({out_valid, quotient, remainder, div_zero, ovf} !== {1'b1, N'(a), {BB{1'b0}}, 2'b00} ||
            {quotient, remainder} !== {e.q, e.r}) begin
          errors++;
          nerr++;
          if (nerr <= 10)
            $display("FAIL sweep %0d/%0d got v=%b q=%0d r=%0d dz=%b ovf=%b want q=%0d r=0", a * b, b,
                     out_valid, $signed(quotient), $signed(remainder), div_zero, ovf, a);
        end
        if (!out_valid) return;
        consume();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_ovf();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
